cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Coprocessor-0 exception controller for the pipelined MIPS core. It sits directly downstream of the address-legality checker in the MEM stage and consumes its `instruction_addr_illegal` / `data_addr_illegal` flags together with the other MEM-stage exception sources. It prioritises exceptions, commits EPC, Cause, BadVAddr and Status, then runs a short flush/redirect sequence. It also supplies `Status_KSU` back to the checker and serves MTC0/MFC0 accesses.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` is held after an exception or ERET (legal range 1–15).
- `EXC_VECTOR`, default 32'h8000_0180: handler address.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: a valid instruction occupies MEM.
- `pc_mem` in 32: PC of the MEM instruction.
- `in_delay_slot` in 1: MEM instruction is in a branch delay slot.
- `instruction_addr_illegal` in 1: fetch address error from the checker.
- `data_addr_illegal` in 1: data address error from the checker.
- `data_addr` in 32: effective data address.
- `load_store_mem` in 3: memory op code. 000 means none; 110 and 111 are stores; other non-zero codes are loads.
- `reserved_inst`, `overflow`, `syscall`, `brk`, `eret` in 1 each: MEM-stage event flags.
- `hw_int` in 6: hardware interrupt lines, level-sensitive.
- `cp0_we` in 1, `cp0_waddr` in 5, `cp0_wdata` in 32: MTC0 write port.
- `cp0_raddr` in 5, `cp0_rdata` out 32: MFC0 read port, combinational.
- `Status_KSU` out 2: effective mode (00 kernel, 01 supervisor, 10 user).
- `flush` out 1: squash IF through MEM.
- `pc_redirect` out 1, `redirect_pc` out 32: PC override.
- `epc_out`, `status_out`, `cause_out` out 32: register taps.

## Operation
- **Registers**:
  - BadVAddr (8) is read-only.
  - Status (12): IM[15:8], KSU[4:3], EXL[1], IE[0] are writable; all other bits read 0.
  - Cause (13): BD[31], IP[15:8], ExcCode[6:2]. Only IP[9:8] are writable.
  - EPC (14) is writable.
  - All registers reset to 0. Unmapped reads return 0.
- **Interrupts**: `Cause.IP[15:10]` is loaded from `hw_int` every cycle. The interrupt is pending when `|(IM & IP)`, IE=1 and EXL=0.
- **Detection** (IDLE, `mem_valid`=1). Priority, highest first, with ExcCode:
  1. Interrupt: 0
  2. Fetch `instruction_addr_illegal`: AdEL, 4
  3. `reserved_inst`: 10
  4. `overflow`: 12
  5. `syscall`: 8
  6. `brk`: 9
  7. `data_addr_illegal` with `load_store_mem`≠000: AdEL 4 for loads, AdES 5 for stores
  - `eret` is taken only if none of the above fire.
- **Exception commit** (one edge):
  - EPC = `in_delay_slot` ? `pc_mem`−4 : `pc_mem`; BD = `in_delay_slot`.
  - ExcCode is set; EXL = 1.
  - BadVAddr = `pc_mem` for fetch AdEL, `data_addr` for data AdEL/AdES, unchanged otherwise.
- **ERET commit**: EXL = 0; target = EPC.
- **`Status_KSU`** = EXL ? 00 : Status.KSU.
- **FSM**:
  - IDLE → FLUSH on an exception or ERET; counter loads `FLUSH_CYCLES`−1.
  - FLUSH decrements the counter and returns to IDLE when the counter is 0.
  - In FLUSH, all event inputs and `mem_valid` are ignored.
- **Collisions and reset**:
  - An exception or ERET and an MTC0 in the same cycle: the exception/ERET update wins for EPC/Status/Cause; the MTC0 is dropped.
  - MTC0 is honoured in any state otherwise.
  - `rst` mid-FLUSH returns to IDLE immediately with all outputs 0.

## Timing
- Detection is combinational in cycle N; the commit happens at the end of N.
- `pc_redirect` is a one-cycle pulse in N+1. `redirect_pc` = `EXC_VECTOR` for exceptions, committed EPC value for ERET.
- `flush` is high for cycles N+1 … N+`FLUSH_CYCLES`. The block is back in IDLE at N+`FLUSH_CYCLES`+1 and can accept a new event that cycle.
- `Status_KSU` and `cp0_rdata` reflect register state with zero latency. Registers update on the clock edge only.
- Reset values: `flush`=0, `pc_redirect`=0, `redirect_pc`=0, `Status_KSU`=00, all register taps 0, state IDLE.

## Structure
- Shared package `cp0_pkg` holds:
  - CP0 register indices (8, 12, 13, 14).
  - ExcCode constants (INT, ADEL, ADES, SYS, BP, RI, OV).
  - FSM state encoding.
  - Store-code decode (`load_store_mem[2:1]==2'b11`).
- One sub-module, `exc_prio_enc`: purely combinational priority encoder producing {take, exccode, is_fetch_adel, is_data_ade}. The top level holds the registers and the FSM.

## Test plan
- **Data AdES**: `load_store_mem`=111, `data_addr_illegal`=1, `pc_mem`=0x0040_0010, `data_addr`=0x0000_1002 → ExcCode 5, BadVAddr 0x0000_1002, EPC 0x0040_0010, EXL=1, `Status_KSU`=00; `pc_redirect` pulses N+1 with 0x8000_0180; `flush` high 2 cycles.
- **Fetch error in delay slot beats overflow**: `instruction_addr_illegal`=1 and `overflow`=1, `in_delay_slot`=1, `pc_mem`=0x0040_0022 → ExcCode 4, BD=1, EPC 0x0040_001E, BadVAddr 0x0040_0022.
- **Interrupt gating and priority**:
  - MTC0 Status=0x0000_0401; `hw_int[0]`=1; `syscall`=1 → ExcCode 0.
  - Same stimulus with EXL=1 → no exception until ERET clears EXL.
- **ERET**: EPC=0x0040_0100, EXL=1, KSU=10, `eret`=1 → redirect 0x0040_0100, EXL=0, `Status_KSU`=10 from N+1.
- **Events during FLUSH**: `syscall` asserted in N+1 → ignored, registers unchanged.
- **Collision and reset**:
  - MTC0 EPC=0x1234 in the same cycle as `brk` → EPC = `pc_mem`.
  - `rst` asserted mid-FLUSH → all outputs 0 asynchronously.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, writable-bit masks,
// FSM encoding and the load/store opcode decode.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status keeps IM, KSU, EXL and IE; software may only touch Cause.IP[9:8].
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF1B;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } cp0_state_t;

    function automatic logic is_store(input logic [2:0] ls_code);
        return ls_code[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational exception priority encoder for the MEM stage.
// Produces the winning exception and whether it reports a fetch or data address.
module exc_prio_enc
    import cp0_pkg::*;
(
    input  logic       i_en,
    input  logic       i_int_pending,
    input  logic       i_fetch_ill,
    input  logic       i_reserved,
    input  logic       i_overflow,
    input  logic       i_syscall,
    input  logic       i_brk,
    input  logic       i_data_ill,
    input  logic [2:0] i_ls_code,
    output logic       o_take,
    output logic [4:0] o_exccode,
    output logic       o_is_fetch_adel,
    output logic       o_is_data_ade
);

    // NOTE: every output gets a default before the if-chain so no latch is inferred.
    always_comb begin
        o_take          = 1'b0;
        o_exccode       = EXC_INT;
        o_is_fetch_adel = 1'b0;
        o_is_data_ade   = 1'b0;
        if (i_en) begin
            if (i_int_pending) begin
                o_take    = 1'b1;
                o_exccode = EXC_INT;
            end else if (i_fetch_ill) begin
                o_take          = 1'b1;
                o_exccode       = EXC_ADEL;
                o_is_fetch_adel = 1'b1;
            end else if (i_reserved) begin
                o_take    = 1'b1;
                o_exccode = EXC_RI;
            end else if (i_overflow) begin
                o_take    = 1'b1;
                o_exccode = EXC_OV;
            end else if (i_syscall) begin
                o_take    = 1'b1;
                o_exccode = EXC_SYS;
            end else if (i_brk) begin
                o_take    = 1'b1;
                o_exccode = EXC_BP;
            end else if (i_data_ill && (i_ls_code != 3'b000)) begin
                o_take        = 1'b1;
                o_exccode     = is_store(i_ls_code) ? EXC_ADES : EXC_ADEL;
                o_is_data_ade = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: prioritises MEM-stage exceptions, commits EPC/Cause/
// BadVAddr/Status, sequences flush/redirect and serves MTC0/MFC0.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] pc_mem,
    input  logic        in_delay_slot,
    input  logic        instruction_addr_illegal,
    input  logic        data_addr_illegal,
    input  logic [31:0] data_addr,
    input  logic [2:0]  load_store_mem,
    input  logic        reserved_inst,
    input  logic        overflow,
    input  logic        syscall,
    input  logic        brk,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [1:0]  Status_KSU,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic [31:0] cause_out
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    cp0_state_t  r_state;
    cp0_state_t  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic [31:0] r_epc;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_badvaddr;
    logic [31:0] w_epc_nxt;
    logic [31:0] w_status_nxt;
    logic [31:0] w_cause_nxt;
    logic [31:0] w_badvaddr_nxt;

    logic        r_pc_redirect;
    logic [31:0] r_redirect_pc;

    logic        w_detect_en;
    logic        w_int_pending;
    logic        w_exc_take;
    logic [4:0]  w_exccode;
    logic        w_is_fetch_adel;
    logic        w_is_data_ade;
    logic        w_eret_take;

    assign w_detect_en   = (r_state == ST_IDLE) && mem_valid;
    assign w_int_pending = (|(r_status[15:8] & r_cause[15:8])) && r_status[0] && !r_status[1];

    exc_prio_enc u_prio (
        .i_en            (w_detect_en),
        .i_int_pending   (w_int_pending),
        .i_fetch_ill     (instruction_addr_illegal),
        .i_reserved      (reserved_inst),
        .i_overflow      (overflow),
        .i_syscall       (syscall),
        .i_brk           (brk),
        .i_data_ill      (data_addr_illegal),
        .i_ls_code       (load_store_mem),
        .o_take          (w_exc_take),
        .o_exccode       (w_exccode),
        .o_is_fetch_adel (w_is_fetch_adel),
        .o_is_data_ade   (w_is_data_ade)
    );

    assign w_eret_take = w_detect_en && eret && !w_exc_take;

    // Exception/ERET updates take precedence; a colliding MTC0 is simply dropped.
    always_comb begin
        w_epc_nxt      = r_epc;
        w_status_nxt   = r_status;
        w_cause_nxt    = r_cause;
        w_badvaddr_nxt = r_badvaddr;
        if (w_exc_take) begin
            w_epc_nxt        = in_delay_slot ? (pc_mem - 32'd4) : pc_mem;
            w_cause_nxt[31]  = in_delay_slot;
            w_cause_nxt[6:2] = w_exccode;
            w_status_nxt[1]  = 1'b1;
            if (w_is_fetch_adel) begin
                w_badvaddr_nxt = pc_mem;
            end else if (w_is_data_ade) begin
                w_badvaddr_nxt = data_addr;
            end
        end else if (w_eret_take) begin
            w_status_nxt[1] = 1'b0;
        end else if (cp0_we) begin
            case (cp0_waddr)
                CP0_STATUS: w_status_nxt = cp0_wdata & STATUS_WMASK;
                CP0_CAUSE:  w_cause_nxt  = (r_cause & ~CAUSE_WMASK) | (cp0_wdata & CAUSE_WMASK);
                CP0_EPC:    w_epc_nxt    = cp0_wdata;
                default:    ;
            endcase
        end
        w_cause_nxt[15:10] = hw_int;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_exc_take || w_eret_take) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_epc         <= 32'd0;
            r_status      <= 32'd0;
            r_cause       <= 32'd0;
            r_badvaddr    <= 32'd0;
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_epc         <= w_epc_nxt;
            r_status      <= w_status_nxt;
            r_cause       <= w_cause_nxt;
            r_badvaddr    <= w_badvaddr_nxt;
            r_pc_redirect <= w_exc_take || w_eret_take;
            if (w_exc_take) begin
                r_redirect_pc <= EXC_VECTOR;
            end else if (w_eret_take) begin
                r_redirect_pc <= r_epc;
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = r_badvaddr;
            CP0_STATUS:   cp0_rdata = r_status;
            CP0_CAUSE:    cp0_rdata = r_cause;
            CP0_EPC:      cp0_rdata = r_epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign Status_KSU  = r_status[1] ? 2'b00 : r_status[4:3];
    assign flush       = (r_state == ST_FLUSH);
    assign pc_redirect = r_pc_redirect;
    assign redirect_pc = r_redirect_pc;
    assign epc_out     = r_epc;
    assign status_out  = r_status;
    assign cause_out   = r_cause;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: inputs change on the falling edge, outputs are
// checked on the following falling edge.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] pc_mem;
    logic        in_delay_slot;
    logic        instruction_addr_illegal;
    logic        data_addr_illegal;
    logic [31:0] data_addr;
    logic [2:0]  load_store_mem;
    logic        reserved_inst, overflow, syscall, brk, eret;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [1:0]  Status_KSU;
    logic        flush, pc_redirect;
    logic [31:0] redirect_pc, epc_out, status_out, cause_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .pc_mem(pc_mem),
        .in_delay_slot(in_delay_slot), .instruction_addr_illegal(instruction_addr_illegal),
        .data_addr_illegal(data_addr_illegal), .data_addr(data_addr),
        .load_store_mem(load_store_mem), .reserved_inst(reserved_inst), .overflow(overflow),
        .syscall(syscall), .brk(brk), .eret(eret), .hw_int(hw_int), .cp0_we(cp0_we),
        .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr),
        .cp0_rdata(cp0_rdata), .Status_KSU(Status_KSU), .flush(flush),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc_out(epc_out),
        .status_out(status_out), .cause_out(cause_out)
    );

    task automatic clear_events();
        mem_valid = 0; pc_mem = 0; in_delay_slot = 0; instruction_addr_illegal = 0;
        data_addr_illegal = 0; data_addr = 0; load_store_mem = 3'b000;
        reserved_inst = 0; overflow = 0; syscall = 0; brk = 0; eret = 0;
        cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we = 1; cp0_waddr = addr; cp0_wdata = data;
        tick();
        cp0_we = 0;
    endtask

    task automatic test_reset();
        cp0_raddr = 5'd8;
        #1;
        if (flush !== 1'b0) begin $display("FAIL reset_flush: got %0b want 0", flush); n_fail++; end n_tests++;
        if (pc_redirect !== 1'b0) begin $display("FAIL reset_redirect: got %0b want 0", pc_redirect); n_fail++; end n_tests++;
        if (redirect_pc !== 32'h0) begin $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); n_fail++; end n_tests++;
        if (Status_KSU !== 2'b00) begin $display("FAIL reset_ksu: got %b want 00", Status_KSU); n_fail++; end n_tests++;
        if ({epc_out, status_out, cause_out, cp0_rdata} !== 128'h0) begin
            $display("FAIL reset_regs: got %h %h %h %h want all 0", epc_out, status_out, cause_out, cp0_rdata); n_fail++;
        end n_tests++;
    endtask

    task automatic test_mtc0_masks();
        mtc0(5'd12, 32'hFFFF_FFFF);
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd8,  32'hDEAD_BEEF);
        if (status_out !== 32'h0000_FF1B) begin $display("FAIL status_mask: got %h want 0000ff1b", status_out); n_fail++; end n_tests++;
        if (cause_out !== 32'h0000_0300) begin $display("FAIL cause_mask: got %h want 00000300", cause_out); n_fail++; end n_tests++;
        if (cp0_rdata !== 32'h0) begin $display("FAIL badvaddr_ro: got %h want 0", cp0_rdata); n_fail++; end n_tests++;
        if (Status_KSU !== 2'b00) begin $display("FAIL ksu_exl: got %b want 00", Status_KSU); n_fail++; end n_tests++;
        mtc0(5'd12, 32'h0000_0018);
        if (Status_KSU !== 2'b11) begin $display("FAIL ksu_plain: got %b want 11", Status_KSU); n_fail++; end n_tests++;
        cp0_raddr = 5'd3;
        #1;
        if (cp0_rdata !== 32'h0) begin $display("FAIL unmapped_read: got %h want 0", cp0_rdata); n_fail++; end n_tests++;
        cp0_raddr = 5'd8;
        mtc0(5'd12, 32'h0);
        mtc0(5'd13, 32'h0);
    endtask

    task automatic test_data_ades();
        mem_valid = 1; load_store_mem = 3'b111; data_addr_illegal = 1;
        pc_mem = 32'h0040_0010; data_addr = 32'h0000_1002;
        tick();
        clear_events();
        if (cause_out !== 32'h0000_0014) begin $display("FAIL ades_cause: got %h want 00000014", cause_out); n_fail++; end n_tests++;
        if (cp0_rdata !== 32'h0000_1002) begin $display("FAIL ades_badvaddr: got %h want 00001002", cp0_rdata); n_fail++; end n_tests++;
        if (epc_out !== 32'h0040_0010) begin $display("FAIL ades_epc: got %h want 00400010", epc_out); n_fail++; end n_tests++;
        if (status_out !== 32'h0000_0002) begin $display("FAIL ades_status: got %h want 00000002", status_out); n_fail++; end n_tests++;
        if (Status_KSU !== 2'b00) begin $display("FAIL ades_ksu: got %b want 00", Status_KSU); n_fail++; end n_tests++;
        if ({pc_redirect, flush} !== 2'b11) begin $display("FAIL ades_n1_pulse: got %b%b want 11", pc_redirect, flush); n_fail++; end n_tests++;
        if (redirect_pc !== 32'h8000_0180) begin $display("FAIL ades_vector: got %h want 80000180", redirect_pc); n_fail++; end n_tests++;
        tick();
        if ({pc_redirect, flush} !== 2'b01) begin $display("FAIL ades_n2: got %b%b want 01", pc_redirect, flush); n_fail++; end n_tests++;
        tick();
        if (flush !== 1'b0) begin $display("FAIL ades_n3_idle: got %0b want 0", flush); n_fail++; end n_tests++;
    endtask

    task automatic test_fetch_delay_slot();
        mem_valid = 1; instruction_addr_illegal = 1; overflow = 1; in_delay_slot = 1;
        pc_mem = 32'h0040_0022;
        tick();
        clear_events();
        if (cause_out !== 32'h8000_0010) begin $display("FAIL fetch_cause: got %h want 80000010", cause_out); n_fail++; end n_tests++;
        if (epc_out !== 32'h0040_001E) begin $display("FAIL fetch_epc: got %h want 0040001e", epc_out); n_fail++; end n_tests++;
        if (cp0_rdata !== 32'h0040_0022) begin $display("FAIL fetch_badvaddr: got %h want 00400022", cp0_rdata); n_fail++; end n_tests++;
        tick(); tick();
    endtask

    task automatic test_interrupt();
        hw_int = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        if (status_out !== 32'h0000_0401) begin $display("FAIL int_status_wr: got %h want 00000401", status_out); n_fail++; end n_tests++;
        if (cause_out !== 32'h8000_0410) begin $display("FAIL int_ip_load: got %h want 80000410", cause_out); n_fail++; end n_tests++;
        mem_valid = 1; syscall = 1; pc_mem = 32'h0040_0040;
        tick();
        clear_events();
        if (cause_out !== 32'h0000_0400) begin $display("FAIL int_beats_sys: got %h want 00000400", cause_out); n_fail++; end n_tests++;
        if (epc_out !== 32'h0040_0040) begin $display("FAIL int_epc: got %h want 00400040", epc_out); n_fail++; end n_tests++;
        if (cp0_rdata !== 32'h0040_0022) begin $display("FAIL int_badv_kept: got %h want 00400022", cp0_rdata); n_fail++; end n_tests++;
        tick(); tick();
        mem_valid = 1; pc_mem = 32'h0040_0050;
        tick();
        clear_events();
        if ({pc_redirect, flush} !== 2'b00) begin $display("FAIL int_gated_exl: got %b%b want 00", pc_redirect, flush); n_fail++; end n_tests++;
        mem_valid = 1; eret = 1; pc_mem = 32'h0040_0054;
        tick();
        clear_events();
        if (pc_redirect !== 1'b1 || redirect_pc !== 32'h0040_0040) begin
            $display("FAIL int_eret: got %b %h want 1 00400040", pc_redirect, redirect_pc); n_fail++;
        end n_tests++;
        if (status_out !== 32'h0000_0401) begin $display("FAIL int_eret_exl: got %h want 00000401", status_out); n_fail++; end n_tests++;
        tick(); tick();
        mem_valid = 1; pc_mem = 32'h0040_0060;
        tick();
        clear_events();
        if (pc_redirect !== 1'b1 || epc_out !== 32'h0040_0060) begin
            $display("FAIL int_after_eret: got %b %h want 1 00400060", pc_redirect, epc_out); n_fail++;
        end n_tests++;
        hw_int = 6'b000000;
        tick(); tick();
    endtask

    task automatic test_eret();
        mtc0(5'd14, 32'h0040_0100);
        mtc0(5'd12, 32'h0000_0012);
        if (Status_KSU !== 2'b00) begin $display("FAIL eret_ksu_before: got %b want 00", Status_KSU); n_fail++; end n_tests++;
        mem_valid = 1; eret = 1; pc_mem = 32'h0040_0200;
        tick();
        clear_events();
        if (pc_redirect !== 1'b1 || redirect_pc !== 32'h0040_0100) begin
            $display("FAIL eret_redirect: got %b %h want 1 00400100", pc_redirect, redirect_pc); n_fail++;
        end n_tests++;
        if (Status_KSU !== 2'b10) begin $display("FAIL eret_ksu_after: got %b want 10", Status_KSU); n_fail++; end n_tests++;
        if (status_out !== 32'h0000_0010) begin $display("FAIL eret_status: got %h want 00000010", status_out); n_fail++; end n_tests++;
        tick(); tick();
    endtask

    task automatic test_flush_events();
        mem_valid = 1; brk = 1; pc_mem = 32'h0040_0300;
        tick();
        clear_events();
        mem_valid = 1; syscall = 1; in_delay_slot = 1; pc_mem = 32'h0040_0400;
        tick();
        clear_events();
        if (epc_out !== 32'h0040_0300) begin $display("FAIL flush_epc_kept: got %h want 00400300", epc_out); n_fail++; end n_tests++;
        if (cause_out !== 32'h0000_0024) begin $display("FAIL flush_cause_kept: got %h want 00000024", cause_out); n_fail++; end n_tests++;
        if ({pc_redirect, flush} !== 2'b01) begin $display("FAIL flush_no_pulse: got %b%b want 01", pc_redirect, flush); n_fail++; end n_tests++;
        tick();
        if (flush !== 1'b0) begin $display("FAIL flush_end: got %0b want 0", flush); n_fail++; end n_tests++;
    endtask

    task automatic test_collision();
        mem_valid = 1; brk = 1; pc_mem = 32'h0040_0500;
        cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h0000_1234;
        tick();
        clear_events();
        if (epc_out !== 32'h0040_0500) begin $display("FAIL collide_epc: got %h want 00400500", epc_out); n_fail++; end n_tests++;
        mtc0(5'd14, 32'h0000_5678);
        if (epc_out !== 32'h0000_5678 || flush !== 1'b1) begin
            $display("FAIL mtc0_in_flush: got %h %0b want 00005678 1", epc_out, flush); n_fail++;
        end n_tests++;
        tick();
    endtask

    task automatic test_rst_mid_flush();
        mem_valid = 1; syscall = 1; pc_mem = 32'h0040_0600;
        tick();
        clear_events();
        if (flush !== 1'b1) begin $display("FAIL rst_pre_flush: got %0b want 1", flush); n_fail++; end n_tests++;
        #2 rst = 1;
        #1;
        if ({flush, pc_redirect, Status_KSU} !== 4'b0000 || redirect_pc !== 32'h0) begin
            $display("FAIL rst_async_ctl: got %b%b%b %h want 0", flush, pc_redirect, Status_KSU, redirect_pc); n_fail++;
        end n_tests++;
        if ({epc_out, status_out, cause_out} !== 96'h0) begin
            $display("FAIL rst_async_regs: got %h %h %h want 0", epc_out, status_out, cause_out); n_fail++;
        end n_tests++;
        tick();
        rst = 0;
        tick();
        if (flush !== 1'b0) begin $display("FAIL rst_idle_after: got %0b want 0", flush); n_fail++; end n_tests++;
    endtask

    initial begin
        rst = 1; hw_int = 0; cp0_raddr = 5'd8;
        clear_events();
        tick(); tick();
        rst = 0;
        test_reset();
        tick();
        test_mtc0_masks();
        test_data_ades();
        test_fetch_delay_slot();
        test_interrupt();
        test_eret();
        test_flush_events();
        test_collision();
        test_rst_mid_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
